// File: rtl/eq_quant_pkg.sv
// Shared constants and helpers for the 4-bit complex equaliser/requantiser.
// All widths derive from the input, gain and output formats below.
package eq_quant_pkg;

    localparam int IN_W      = 18;
    localparam int GAIN_W    = 16;
    localparam int GAIN_FRAC = 8;
    localparam int OUT_W     = 4;
    localparam int N_CHAN    = 1024;
    localparam int CLIP_W    = 16;

    localparam int SH      = GAIN_FRAC + IN_W - OUT_W;
    localparam int OUT_MAX = 2 ** (OUT_W - 1) - 1;
    localparam int OUT_MIN = -OUT_MAX;
    localparam int LATENCY = 4;
    localparam int CHAN_W  = $clog2(N_CHAN);
    localparam int PROD_W  = IN_W + GAIN_W + 1;

    function automatic logic [2*OUT_W-1:0] pack_dout(
        input logic [OUT_W-1:0] re,
        input logic [OUT_W-1:0] im
    );
        return {re, im};
    endfunction

endpackage

// File: rtl/eq_round_sat.sv
// One real lane: gain multiply, round half-up, symmetric saturate.
// Each stage only loads on its valid, so bubbles leave the data held.
module eq_round_sat
    import eq_quant_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     v1,
    input  logic                     v2,
    input  logic                     v3,
    input  logic signed [IN_W-1:0]   din,
    input  logic        [GAIN_W-1:0] gain,
    output logic        [OUT_W-1:0]  dout,
    output logic                     clip
);

    localparam int SUM_W = PROD_W + 1;
    localparam int RND_W = SUM_W - SH;
    localparam logic signed [RND_W-1:0] R_MAX = RND_W'(OUT_MAX);
    localparam logic signed [RND_W-1:0] R_MIN = RND_W'(OUT_MIN);

    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic signed [RND_W-1:0]  rnd_q, rnd_d;
    logic        [OUT_W-1:0]  dout_q, dout_d;
    logic signed [SUM_W-1:0]  sum;
    logic        [OUT_W-1:0]  sat;
    logic                     over;
    logic                     under;

    always_comb begin
        prod_d = prod_q;
        if (v1) begin
            prod_d = PROD_W'(din) * PROD_W'($signed({1'b0, gain}));
        end

        // floor((p + half) / 2^SH) == arithmetic shift of the biased sum
        sum   = SUM_W'(prod_q) + (SUM_W'(1) <<< (SH - 1));
        rnd_d = v2 ? RND_W'(sum >>> SH) : rnd_q;

        over  = rnd_q > R_MAX;
        under = rnd_q < R_MIN;
        sat   = rnd_q[OUT_W-1:0];
        unique case (1'b1)
            over:    sat = OUT_W'(OUT_MAX);
            under:   sat = OUT_W'(OUT_MIN);
            default: sat = rnd_q[OUT_W-1:0];
        endcase

        clip   = v3 && (over || under);
        dout_d = v3 ? sat : dout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            rnd_q  <= '0;
            dout_q <= '0;
        end else begin
            prod_q <= prod_d;
            rnd_q  <= rnd_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/eq_quant4_cplx.sv
// Complex equalise-and-requantise stage: gain shadow, delay line,
// channel/sync tracking and per-frame clip statistics.
module eq_quant4_cplx
    import eq_quant_pkg::*;
(
    input  logic                 user_clk,
    input  logic                 user_rst,
    input  logic [31:0]          gain_in,
    input  logic                 sync_in,
    input  logic                 valid_in,
    input  logic [IN_W-1:0]      din_re,
    input  logic [IN_W-1:0]      din_im,
    output logic                 sync_out,
    output logic                 valid_out,
    output logic [2*OUT_W-1:0]   dout,
    output logic [CLIP_W-1:0]    clip_count,
    output logic                 sync_err
);

    logic        [GAIN_W-1:0]  gain_q, gain_d;
    logic        [CHAN_W-1:0]  chan_q, chan_d;
    logic                      serr_q, serr_d;
    logic        [LATENCY-1:0] vld_q, vld_d;
    logic        [LATENCY-1:0] syn_q, syn_d;
    logic signed [IN_W-1:0]    re_q, re_d;
    logic signed [IN_W-1:0]    im_q, im_d;
    logic        [CLIP_W-1:0]  run_q, run_d;
    logic        [CLIP_W-1:0]  clip_cnt_q, clip_cnt_d;

    logic [OUT_W-1:0] lane_re;
    logic [OUT_W-1:0] lane_im;
    logic             clip_re;
    logic             clip_im;
    logic             clip_any;
    logic             unused_gain_hi;

    assign unused_gain_hi = ^gain_in[31:GAIN_W];

    always_comb begin
        gain_d = sync_in ? gain_in[GAIN_W-1:0] : gain_q;
        vld_d  = {vld_q[LATENCY-2:0], valid_in};
        syn_d  = {syn_q[LATENCY-2:0], sync_in};
        re_d   = valid_in ? din_re : re_q;
        im_d   = valid_in ? din_im : im_q;

        // chan_q holds the index the next valid sample will take
        serr_d = serr_q | (sync_in && chan_q != '0);
        chan_d = chan_q;
        if (sync_in) begin
            chan_d = valid_in ? CHAN_W'(1) : '0;
        end else if (valid_in) begin
            chan_d = chan_q + CHAN_W'(1);
        end

        clip_any   = clip_re | clip_im;
        run_d      = run_q;
        clip_cnt_d = clip_cnt_q;
        if (syn_q[LATENCY-2]) begin
            clip_cnt_d = run_q;
            run_d      = CLIP_W'(clip_any);
        end else if (clip_any && run_q != '1) begin
            run_d = run_q + CLIP_W'(1);
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            gain_q     <= '0;
            chan_q     <= '0;
            serr_q     <= 1'b0;
            vld_q      <= '0;
            syn_q      <= '0;
            re_q       <= '0;
            im_q       <= '0;
            run_q      <= '0;
            clip_cnt_q <= '0;
        end else begin
            gain_q     <= gain_d;
            chan_q     <= chan_d;
            serr_q     <= serr_d;
            vld_q      <= vld_d;
            syn_q      <= syn_d;
            re_q       <= re_d;
            im_q       <= im_d;
            run_q      <= run_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    eq_round_sat u_lane_re (
        .clk  (user_clk),
        .rst  (user_rst),
        .v1   (vld_q[0]),
        .v2   (vld_q[1]),
        .v3   (vld_q[2]),
        .din  (re_q),
        .gain (gain_q),
        .dout (lane_re),
        .clip (clip_re)
    );

    eq_round_sat u_lane_im (
        .clk  (user_clk),
        .rst  (user_rst),
        .v1   (vld_q[0]),
        .v2   (vld_q[1]),
        .v3   (vld_q[2]),
        .din  (im_q),
        .gain (gain_q),
        .dout (lane_im),
        .clip (clip_im)
    );

    assign sync_out   = syn_q[LATENCY-1];
    assign valid_out  = vld_q[LATENCY-1];
    assign dout       = pack_dout(lane_re, lane_im);
    assign clip_count = clip_cnt_q;
    assign sync_err   = serr_q;

endmodule

// File: tb/tb_eq_quant4_cplx.sv
// Directed scoreboard bench for eq_quant4_cplx.
module tb_eq_quant4_cplx;

    logic        user_clk = 1'b0;
    logic        user_rst = 1'b1;
    logic [31:0] gain_in  = '0;
    logic        sync_in  = 1'b0;
    logic        valid_in = 1'b0;
    logic [17:0] din_re   = '0;
    logic [17:0] din_im   = '0;
    logic        sync_out;
    logic        valid_out;
    logic [7:0]  dout;
    logic [15:0] clip_count;
    logic        sync_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [8:0]  sb[$];
    logic [8:0]  exp_item;
    logic [31:0] cur_gain = '0;
    logic [3:0]  vhist    = '0;
    bit          bub_win  = 1'b0;

    always #5 user_clk = ~user_clk;

    eq_quant4_cplx dut (
        .user_clk   (user_clk),
        .user_rst   (user_rst),
        .gain_in    (gain_in),
        .sync_in    (sync_in),
        .valid_in   (valid_in),
        .din_re     (din_re),
        .din_im     (din_im),
        .sync_out   (sync_out),
        .valid_out  (valid_out),
        .dout       (dout),
        .clip_count (clip_count),
        .sync_err   (sync_err)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input bit s, input int re, input int im,
                        input logic [7:0] e);
        @(posedge user_clk);
        #1;
        sync_in  = s;
        valid_in = 1'b1;
        din_re   = 18'(re);
        din_im   = 18'(im);
        gain_in  = cur_gain;
        sb.push_back({s, e});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge user_clk);
            #1;
            sync_in  = 1'b0;
            valid_in = 1'b0;
            gain_in  = cur_gain;
        end
    endtask

    always @(posedge user_clk) vhist <= {vhist[2:0], valid_in};

    // Monitor: pop one expectation per presented output
    always @(negedge user_clk) begin
        if (valid_out) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got dout %0h, none expected", dout);
            end else begin
                exp_item = sb.pop_front();
                check("sync_dout", {23'b0, sync_out, dout}, {23'b0, exp_item});
            end
        end
        if (bub_win) check("valid_delay4", {31'b0, valid_out}, {31'b0, vhist[3]});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge user_clk);
        #1;
        check("rst_dout", {24'b0, dout}, 32'h0);
        check("rst_valid", {31'b0, valid_out}, 32'h0);
        check("rst_sync", {31'b0, sync_out}, 32'h0);
        check("rst_clip", {16'b0, clip_count}, 32'h0);
        check("rst_serr", {31'b0, sync_err}, 32'h0);
        user_rst = 1'b0;
        idle(6);

        // Frame A: unity gain, rounding, bubbles, clip on each lane
        cur_gain = 32'd256;
        bub_win  = 1'b1;
        send(1, 32768, -32768, 8'h2E);
        send(0, 40960, 0, 8'h30);
        send(0, -40960, 0, 8'hE0);
        send(0, 24576, 0, 8'h20);
        idle(1);
        send(0, 32768, 32768, 8'h22);
        idle(2);
        send(0, -32768, 0, 8'hE0);
        for (int i = 6; i < 1024; i++) begin
            if (i == 14) bub_win = 1'b0;
            if (i >= 10 && i <= 12) send(0, 131071, 0, 8'h70);
            else if (i == 13) send(0, 0, -131072, 8'h09);
            else send(0, 0, 0, 8'h00);
        end

        // Frame B: 16x gain, every sample clips
        cur_gain = 32'd4096;
        for (int i = 0; i < 1024; i++) begin
            send(i == 0, 131071, -131072, 8'h79);
            if (i == 10) check("clip_frame_a", {16'b0, clip_count}, 32'd4);
        end

        // Frame C: gain_in changes mid-frame but must not take effect
        cur_gain = 32'd256;
        for (int i = 0; i < 1024; i++) begin
            if (i == 500) cur_gain = 32'd512;
            send(i == 0, 32768, 0, 8'h20);
            if (i == 10) check("clip_frame_b", {16'b0, clip_count}, 32'd1024);
        end

        // Frame D: new gain at sync, then an early sync at channel 700
        for (int i = 0; i < 700; i++) begin
            if (i == 1) send(0, 131071, 0, 8'h70);
            else send(i == 0, 32768, 0, 8'h40);
            if (i == 10) check("clip_frame_c", {16'b0, clip_count}, 32'd0);
        end
        check("serr_before", {31'b0, sync_err}, 32'h0);
        send(1, 32768, 0, 8'h40);
        idle(5);
        check("serr_set", {31'b0, sync_err}, 32'h1);
        check("clip_frame_d", {16'b0, clip_count}, 32'd1);
        for (int i = 0; i < 5; i++) send(0, 32768, 0, 8'h40);
        idle(6);
        check("serr_sticky", {31'b0, sync_err}, 32'h1);

        // Reset with samples in flight
        send(0, 32768, 0, 8'h40);
        send(0, 32768, 0, 8'h40);
        #2;
        user_rst = 1'b1;
        valid_in = 1'b0;
        sb.delete();
        #1;
        check("mrst_dout", {24'b0, dout}, 32'h0);
        check("mrst_valid", {31'b0, valid_out}, 32'h0);
        check("mrst_clip", {16'b0, clip_count}, 32'h0);
        check("mrst_serr", {31'b0, sync_err}, 32'h0);
        repeat (2) @(posedge user_clk);
        #1;
        user_rst = 1'b0;
        idle(2);

        // Active gain is zero until a sync loads one
        cur_gain = 32'd512;
        send(0, 131071, 131071, 8'h00);
        idle(10);
        check("sb_drained", sb.size(), 32'd0);
        check("serr_after_rst", {31'b0, sync_err}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
